// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core types and pipeline constants
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ALU_STAGES = 3;
  typedef logic [4:0] reg_addr_t;
  localparam reg_addr_t REG_X0 = 5'd0;
endpackage

// File: rtl/riscv_sb_counter.sv
// riscv_sb_counter: saturating in-flight write counter for one architectural register
module riscv_sb_counter #(
  parameter int MAX = 4,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero,
  output logic full,
  output logic underflow,
  output logic nxt_nz
);
  logic [W-1:0] cnt, cnt_nxt;
  assign zero = cnt == '0;
  assign full = cnt == W'(MAX);
  assign underflow = dec & zero;
  // simultaneous inc and dec cancel, including the underflow case
  always_comb cnt_nxt = clr ? '0
                      : (inc & !dec & !full) ? cnt + 1'b1
                      : (dec & !inc & !zero) ? cnt - 1'b1
                      : cnt;
  assign nxt_nz = |cnt_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_nxt;
endmodule

// File: rtl/riscv_wb_scoreboard.sv
// riscv_wb_scoreboard: EX4 writeback register plus per-register RAW scoreboard with flush drain
module riscv_wb_scoreboard
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int DRAIN_CYCLES = ALU_STAGES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  reg_addr_t       issue_rd,
  input  reg_addr_t       issue_rs1,
  input  reg_addr_t       issue_rs2,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  output logic            issue_stall,
  input  logic            flush,
  input  logic            wb_valid,
  input  reg_addr_t       wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            rf_we,
  output reg_addr_t       rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            pending_any,
  output logic            sb_err
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  logic [NUM_REGS-1:0] zero, full, under, nz;
  logic [DW-1:0] drain;
  logic accept;
  assign zero[0] = 1'b1;
  assign full[0] = 1'b0;
  assign under[0] = 1'b0;
  assign nz[0] = 1'b0;
  genvar i;
  for (i = 1; i < NUM_REGS; i++) begin : g_cnt
    riscv_sb_counter #(.MAX(MAX_INFLIGHT)) u_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .inc(accept && issue_rd == reg_addr_t'(i)),
      .dec(rf_we && rf_waddr == reg_addr_t'(i)),
      .clr(flush),
      .zero(zero[i]),
      .full(full[i]),
      .underflow(under[i]),
      .nxt_nz(nz[i])
    );
  end
  // x0 entries are tied so register zero never stalls or counts
  assign issue_stall = flush | (drain != '0)
                     | (issue_use_rs1 & !zero[issue_rs1])
                     | (issue_use_rs2 & !zero[issue_rs2])
                     | full[issue_rd];
  assign accept = issue_valid & !issue_stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf_we <= 1'b0;
      drain <= '0;
      sb_err <= 1'b0;
      pending_any <= 1'b0;
    end else begin
      rf_we <= wb_valid && wb_rd != REG_X0 && drain == '0 && !flush;
      drain <= flush ? DW'(DRAIN_CYCLES) : (drain != '0) ? drain - 1'b1 : drain;
      sb_err <= sb_err | (|under);
      pending_any <= |nz;
    end
  always_ff @(posedge clk)
    if (wb_valid) begin
      rf_waddr <= wb_rd;
      rf_wdata <= wb_data;
    end
endmodule

// File: tb/tb_riscv_wb_scoreboard.sv
// tb_riscv_wb_scoreboard: directed plus randomized checks against a per-register count model
module tb_riscv_wb_scoreboard;
  logic clk = 1'b0, rst_n = 1'b0;
  logic issue_valid = 0, issue_use_rs1 = 0, issue_use_rs2 = 0, flush = 0, wb_valid = 0;
  logic [4:0] issue_rd = 0, issue_rs1 = 0, issue_rs2 = 0, wb_rd = 0;
  logic [31:0] wb_data = 0;
  logic issue_stall, rf_we, pending_any, sb_err;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;

  riscv_wb_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .issue_stall(issue_stall),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_any(pending_any), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int m_cnt[32];
  bit m_we, m_err, last_acc;
  int m_wa, m_drain;
  logic [31:0] m_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_we = 0; m_err = 0; m_drain = 0; m_wa = 0; m_wd = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_pend", pending_any, 0);
    chk("rst_err", sb_err, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: apply inputs, check stall before the edge, advance model, check registered outputs after
  task automatic cyc(input bit iv, input int rd, input int rs1, input int rs2, input bit u1, input bit u2,
                     input bit fl, input bit wv, input int wrd, input logic [31:0] wd);
    bit ms, any, inc, dec;
    issue_valid = iv; issue_rd = 5'(rd); issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2);
    issue_use_rs1 = u1; issue_use_rs2 = u2; flush = fl;
    wb_valid = wv; wb_rd = 5'(wrd); wb_data = wd;
    ms = fl || m_drain > 0 || (u1 && rs1 != 0 && m_cnt[rs1] != 0) ||
         (u2 && rs2 != 0 && m_cnt[rs2] != 0) || (rd != 0 && m_cnt[rd] == 4);
    #1;
    if (iv) chk("stall", issue_stall, ms);
    last_acc = iv && !ms;
    if (m_we && m_cnt[m_wa] == 0) m_err = 1;
    for (int r = 1; r < 32; r++) begin
      inc = last_acc && rd == r;
      dec = m_we && m_wa == r;
      if (fl) m_cnt[r] = 0;
      else if (inc && !dec) m_cnt[r]++;
      else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
    end
    m_we = wv && wrd != 0 && m_drain == 0 && !fl;
    if (wv) begin m_wa = wrd; m_wd = wd; end
    m_drain = fl ? 3 : (m_drain > 0 ? m_drain - 1 : 0);
    any = 0;
    foreach (m_cnt[r]) if (m_cnt[r] != 0) any = 1;
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("waddr", rf_waddr, m_wa);
      chk("wdata", rf_wdata, m_wd);
    end
    chk("pending", pending_any, any);
    chk("sb_err", sb_err, m_err);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int q[$];
    int rd, rs1, rs2, wrd;
    bit iv, u1, u2, fl, wv;
    logic [31:0] wd;
    repeat (2) @(posedge clk);
    do_reset();
    // basic RAW hazard on x5
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("p5", pending_any, 1);
    cyc(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    chk("stall_x5", issue_stall, 1);
    cyc(1, 0, 5, 0, 1, 0, 0, 1, 5, 32'hDEADBEEF);
    chk("we_x5", rf_we, 1);
    chk("wa_x5", rf_waddr, 5);
    chk("wd_x5", rf_wdata, 32'hDEADBEEF);
    chk("stall_commit", issue_stall, 1);
    cyc(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    chk("stall_drop", issue_stall, 0);
    idle();
    // saturation on x7
    repeat (4) cyc(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("full7", issue_stall, 1);
    cyc(1, 7, 0, 0, 0, 0, 0, 1, 7, 32'h7);
    cyc(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("unfull7", issue_stall, 0);
    cyc(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h77);
    idle();
    chk("x7_clear", pending_any, 0);
    // issue and commit to x3 on the same edge
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h3);
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("cancel_pend", pending_any, 1);
    chk("cancel_err", sb_err, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33);
    idle();
    // x0 writeback and x0 source
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234);
    chk("x0_we", rf_we, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("x0_stall", issue_stall, 0);
    // flush with cnt[9]=2, then drain window
    repeat (2) cyc(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("flush_pend", pending_any, 0);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 1, 9, 32'h9);
    chk("drain_we", rf_we, 0);
    chk("drain_err", sb_err, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_drain_acc", last_acc, 1);
    chk("post_drain_pend", pending_any, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11);
    idle();
    // underflow on x12 sets a sticky error
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC);
    chk("uf_we", rf_we, 1);
    idle();
    chk("uf_err", sb_err, 1);
    idle();
    chk("uf_sticky", sb_err, 1);
    do_reset();
    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      iv = ($urandom % 4) != 0;
      rd = $urandom_range(0, 7);
      rs1 = $urandom_range(0, 7);
      rs2 = $urandom_range(0, 7);
      u1 = 1'($urandom);
      u2 = 1'($urandom);
      fl = ($urandom % 40) == 0;
      wv = 0; wrd = 0;
      wd = $urandom;
      if (q.size() > 0 && ($urandom % 3) != 0) begin
        wv = 1;
        wrd = q.pop_front();
      end
      cyc(iv, rd, rs1, rs2, u1, u2, fl, wv, wrd, wd);
      if (fl) q.delete();
      else if (last_acc && rd != 0) q.push_back(rd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
